// File: rtl/top_servo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : top_servo_pkg
//  Description : Shared constants, types and integer helpers for the servo
//                PWM controller. Cycle constants assume a 100 MHz clock.
//  Contents    : FRAME_CYC, MIN_CYC, STEP_CYC, MAX_DEG, NEUTRAL_CYC,
//                CNT_W / DEG_W widths, cyc_t / deg_t types, clamp_deg().
//  Revision    : 1.0 - initial release
// ============================================================================
package top_servo_pkg;

    localparam int FRAME_CYC   = 2_000_000;   // 20 ms frame
    localparam int MIN_CYC     = 100_000;     // 1 ms pulse at 0 degrees
    localparam int STEP_CYC    = 555;         // pulse growth per degree
    localparam int MAX_DEG     = 180;
    localparam int NEUTRAL_CYC = 150_000;     // 1.5 ms pulse used out of reset

    localparam int CNT_W = 21;                // frame counter and width
    localparam int DEG_W = 8;                 // 0..180 fits in 8 bits

    typedef logic [CNT_W-1:0] cyc_t;
    typedef logic [DEG_W-1:0] deg_t;

    // Saturate a signed command (range -90..270) into 0..MAX_DEG.
    function automatic deg_t clamp_deg(input logic signed [9:0] v);
        if (int'(v) < 0) begin
            return '0;
        end else if (int'(v) > MAX_DEG) begin
            return deg_t'(MAX_DEG);
        end else begin
            return deg_t'(v);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/servo_pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : servo_pwm_gen
//  Description : Frame counter, per-frame width register and PWM compare.
//                The width is reloaded only on the last clock of a frame so
//                a pulse never changes length mid-frame.
//  Ports       : clk          - clock
//                rst_n        - synchronous reset, active-high
//                i_width_next - width to use for the next frame (clocks)
//                i_fault_next - forces the output low when set
//                o_pwm        - registered PWM output
//  Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_gen
    import top_servo_pkg::*;
#(
    parameter int FRAME_CYC   = top_servo_pkg::FRAME_CYC,
    parameter int NEUTRAL_CYC = top_servo_pkg::NEUTRAL_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  cyc_t       i_width_next,
    input  logic       i_fault_next,
    output logic       o_pwm
);

    localparam cyc_t c_last_cnt = cyc_t'(FRAME_CYC - 1);

    cyc_t r_count;
    cyc_t r_width;
    logic r_pwm;
    logic w_frame_last;

    assign w_frame_last = (r_count == c_last_cnt);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_count <= '0;
            r_width <= cyc_t'(NEUTRAL_CYC);
            r_pwm   <= 1'b0;
        end else begin
            r_count <= w_frame_last ? '0 : r_count + cyc_t'(1);
            if (w_frame_last) begin
                r_width <= i_width_next;
            end
            // Compare uses the pre-increment count: exactly r_width high
            // clocks per frame, one clock behind the counter.
            r_pwm <= (r_count < r_width) && !i_fault_next;
        end
    end

    assign o_pwm = r_pwm;

endmodule
`default_nettype wire

// File: rtl/top_servo.sv
`default_nettype none
// ============================================================================
//  Module      : top_servo
//  Description : Servo controller. Converts the real-valued target and
//                measured angles to integer degrees, applies a proportional
//                correction, and drives a 20 ms PWM frame. An overcurrent
//                condition latches a fault that holds the output low until
//                reset.
//  Ports       : clk             - clock, rising edge
//                rst_n           - synchronous reset, active-high
//                grades          - target angle, degrees (real)
//                measure_current - motor current, amps, signed (real)
//                measure_grades  - measured shaft angle, degrees (real)
//                pwm_out         - registered servo PWM drive
//  Revision    : 1.0 - initial release
// ============================================================================
module top_servo
    import top_servo_pkg::*;
#(
    parameter int  CLK_HZ      = 100_000_000,
    parameter int  FRAME_CYC   = top_servo_pkg::FRAME_CYC,
    parameter int  MIN_CYC     = top_servo_pkg::MIN_CYC,
    parameter int  STEP_CYC    = top_servo_pkg::STEP_CYC,
    parameter real I_LIMIT     = 2.0,
    parameter int  NEUTRAL_CYC = top_servo_pkg::NEUTRAL_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  real  grades,
    input  real  measure_current,
    input  real  measure_grades,
    output logic pwm_out
);

    // CLK_HZ is informational; the cycle constants are already scaled.
    if (CLK_HZ <= 0) begin : g_bad_clk_hz
        $error("top_servo: CLK_HZ must be positive");
    end

    // Clamp to 0..180 then round to nearest; values are non-negative here,
    // so adding 0.5 and truncating rounds ties away from zero.
    function automatic deg_t deg_from_real(input real d);
        real c;
        if (d < 0.0) begin
            c = 0.0;
        end else if (d > real'(MAX_DEG)) begin
            c = real'(MAX_DEG);
        end else begin
            c = d;
        end
        return deg_t'($rtoi(c + 0.5));
    endfunction

    deg_t              w_tgt;
    deg_t              w_meas;
    logic signed [8:0] w_err;
    logic signed [9:0] w_cmd_raw;
    deg_t              w_cmd;
    cyc_t              w_width_next;
    logic              w_over;
    logic              w_fault_next;
    logic              r_fault;

    always_comb begin
        w_tgt  = deg_from_real(grades);
        w_meas = deg_from_real(measure_grades);
        w_err  = $signed({1'b0, w_tgt}) - $signed({1'b0, w_meas});
        // Half the error added back; >>> floors toward minus infinity.
        w_cmd_raw = $signed({2'b00, w_tgt}) + ($signed({w_err[8], w_err}) >>> 1);
        w_cmd     = clamp_deg(w_cmd_raw);
        w_width_next = cyc_t'(MIN_CYC + int'(w_cmd) * STEP_CYC);
    end

    // Strict comparison: a current exactly at the limit does not trip.
    assign w_over       = (measure_current > I_LIMIT) || (measure_current < -I_LIMIT);
    assign w_fault_next = r_fault | w_over;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_fault_next;
        end
    end

    servo_pwm_gen #(
        .FRAME_CYC   (FRAME_CYC),
        .NEUTRAL_CYC (NEUTRAL_CYC)
    ) u_pwm_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_width_next (w_width_next),
        .i_fault_next (w_fault_next),
        .o_pwm        (pwm_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_top_servo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_top_servo
//  Description : Directed testbench for top_servo, using a shortened frame
//                (1000 clocks, 100 + 4*deg pulse, 600 neutral) so that many
//                frames fit in a short run. Each run_cycles() window is
//                aligned to a frame, so its high count is the pulse width.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_top_servo;

    localparam int F_CYC   = 1000;
    localparam int M_CYC   = 100;
    localparam int S_CYC   = 4;
    localparam int N_CYC   = 600;

    logic clk = 1'b0;
    logic rst_n;
    real  grades;
    real  measure_current;
    real  measure_grades;
    logic pwm_out;

    int n_checks = 0;
    int n_errors = 0;
    int hi;
    int hi2;

    always #5 clk = ~clk;

    top_servo #(
        .CLK_HZ      (100_000_000),
        .FRAME_CYC   (F_CYC),
        .MIN_CYC     (M_CYC),
        .STEP_CYC    (S_CYC),
        .I_LIMIT     (2.0),
        .NEUTRAL_CYC (N_CYC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .grades          (grades),
        .measure_current (measure_current),
        .measure_grades  (measure_grades),
        .pwm_out         (pwm_out)
    );

    task automatic check_value(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Count pwm_out high samples over n clocks, sampled on falling edges.
    task automatic run_cycles(input int n, output int high);
        high = 0;
        repeat (n) begin
            @(negedge clk);
            if (pwm_out === 1'b1) high++;
        end
    endtask

    // Hold reset two clocks, check the output is low, release on a falling edge.
    task automatic do_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_value("pwm_in_reset", int'(pwm_out), 0);
        rst_n = 1'b0;
    endtask

    task automatic set_angles(input real t, input real m);
        grades         = t;
        measure_grades = m;
    endtask

    initial begin
        rst_n           = 1'b1;
        grades          = 0.0;
        measure_grades  = 0.0;
        measure_current = 0.0;
        @(negedge clk);
        do_reset();

        // First frame at neutral, then 0 degrees.
        run_cycles(F_CYC, hi); check_value("frame1_neutral", hi, N_CYC);
        run_cycles(F_CYC, hi); check_value("frame2_zero", hi, 100);
        run_cycles(F_CYC, hi); check_value("frame3_zero", hi, 100);

        // Each new setting: current frame keeps old width, next frame uses new.
        set_angles(90.0, 90.0);
        run_cycles(F_CYC, hi); check_value("hold_before_90", hi, 100);
        run_cycles(F_CYC, hi); check_value("cmd90", hi, 460);

        set_angles(90.0, 80.0);
        run_cycles(F_CYC, hi); check_value("hold_before_95", hi, 460);
        run_cycles(F_CYC, hi); check_value("cmd95", hi, 480);

        set_angles(90.0, 100.0);
        run_cycles(F_CYC, hi);
        run_cycles(F_CYC, hi); check_value("cmd85", hi, 440);

        set_angles(200.0, 180.0);
        run_cycles(F_CYC, hi);
        run_cycles(F_CYC, hi); check_value("clamp_hi_180", hi, 820);

        set_angles(-10.0, 0.0);
        run_cycles(F_CYC, hi);
        run_cycles(F_CYC, hi); check_value("clamp_lo_0", hi, 100);

        // 89.5 rounds to 90, 10.4 rounds to 10: cmd = 90 + 40 = 130.
        set_angles(89.5, 10.4);
        run_cycles(F_CYC, hi);
        run_cycles(F_CYC, hi); check_value("round_cmd130", hi, 620);

        // error -3 >>> 1 = -2 (floor): cmd = 48.
        set_angles(50.0, 53.0);
        run_cycles(F_CYC, hi);
        run_cycles(F_CYC, hi); check_value("floor_cmd48", hi, 292);

        // Mid-frame change: current frame stays 292, next frame 820.
        set_angles(90.0, 90.0);
        run_cycles(F_CYC / 2, hi);
        set_angles(180.0, 180.0);
        run_cycles(F_CYC / 2, hi2);
        check_value("midframe_unchanged", hi + hi2, 292);
        run_cycles(F_CYC, hi); check_value("midframe_next", hi, 820);

        // Current exactly at the limit (either sign) does not trip.
        measure_current = 2.0;
        run_cycles(F_CYC, hi); check_value("at_limit_pos", hi, 820);
        measure_current = -2.0;
        run_cycles(F_CYC, hi); check_value("at_limit_neg", hi, 820);
        measure_current = 0.0;

        // Positive overcurrent mid-pulse: low from the next edge, latched.
        run_cycles(300, hi); check_value("pre_trip_pos", hi, 300);
        measure_current = 2.5;
        run_cycles(F_CYC - 300, hi); check_value("trip_pos_rest", hi, 0);
        measure_current = 0.0;
        run_cycles(F_CYC, hi); check_value("latched_pos_f1", hi, 0);
        run_cycles(F_CYC, hi); check_value("latched_pos_f2", hi, 0);

        // Reset mid-frame clears the fault and restarts at neutral.
        run_cycles(123, hi);
        do_reset();
        run_cycles(F_CYC, hi); check_value("after_reset_neutral", hi, N_CYC);
        run_cycles(F_CYC, hi); check_value("after_reset_cmd180", hi, 820);

        // Negative overcurrent mid-pulse.
        run_cycles(100, hi); check_value("pre_trip_neg", hi, 100);
        measure_current = -2.5;
        run_cycles(F_CYC - 100, hi); check_value("trip_neg_rest", hi, 0);
        measure_current = 0.0;
        run_cycles(F_CYC, hi); check_value("latched_neg", hi, 0);

        // Trip on the frame-boundary clock: output stays low afterwards.
        do_reset();
        set_angles(0.0, 0.0);
        run_cycles(F_CYC - 1, hi); check_value("boundary_pre", hi, N_CYC);
        measure_current = 2.5;
        run_cycles(1, hi); check_value("boundary_trip", hi, 0);
        measure_current = 0.0;
        run_cycles(F_CYC, hi); check_value("boundary_latched", hi, 0);

        // Final recovery.
        do_reset();
        run_cycles(F_CYC, hi); check_value("final_neutral", hi, N_CYC);
        run_cycles(F_CYC, hi); check_value("final_zero", hi, 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/top_servo.md
TOP_SERVO -- requirements
Module: top_servo

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency in Hz (documentation only; cycle constants below are fixed for this value).
REQ-002 Parameter FRAME_CYC, default 2_000_000, PWM frame length in clocks (20 ms).
REQ-003 Parameter MIN_CYC, default 100_000, pulse width at 0 degrees (1 ms).
REQ-004 Parameter STEP_CYC, default 555, pulse-width increment per degree.
REQ-005 Parameter I_LIMIT, default 2.0 (real, amps), overcurrent threshold.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-high (asserted = 1).
REQ-008 grades  input  real  target angle in degrees.
REQ-009 measure_current  input  real  measured motor current in amps, signed.
REQ-010 measure_grades  input  real  measured shaft angle in degrees.
REQ-011 pwm_out  output  1  servo PWM drive, registered.

Function
REQ-012 Frame counter `count` SHALL run 0..FRAME_CYC-1 and wrap to 0, incrementing once per clock.
REQ-013 On the clock where count == FRAME_CYC-1, grades and measure_grades SHALL be sampled, clamped to 0.0..180.0, and converted to integers 0..180 by round-to-nearest (ties away from zero).
REQ-014 On the same clock: error = target - measured (signed, 9 bits); cmd = target + (error >>> 1) (arithmetic shift, floor); cmd clamped to 0..180.
REQ-015 On the same clock, width SHALL load MIN_CYC + cmd*STEP_CYC (21-bit unsigned; range 100_000..199_900). The new width takes effect from count == 0 of the next frame. Width never changes mid-frame.
REQ-016 Every non-reset clock, pwm_out SHALL be loaded with (count < width) && !fault_next, using the pre-increment count. This gives exactly `width` high cycles per frame, delayed one clock from count.
REQ-017 fault_next = fault | (|measure_current| > I_LIMIT), evaluated every clock. The fault flop SHALL load fault_next.
REQ-018 Once set, fault SHALL latch until reset. While fault is set, pwm_out SHALL be 0. The frame counter and width update SHALL continue.
REQ-019 A current exactly equal to I_LIMIT SHALL NOT trip the fault.
REQ-020 A simultaneous fault trip and frame-boundary update: both SHALL take effect. The width loads, and pwm_out stays 0.

Reset
REQ-021 While rst_n == 1 at a clock edge: count = 0, width = 150_000 (90-degree neutral), fault = 0, pwm_out = 0.
REQ-022 On the first clock after rst_n returns to 0, count SHALL be 0 and pwm_out SHALL be loaded with 1. The first frame therefore uses width 150_000.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately and clear a latched fault.

Structure
REQ-024 Package top_servo_pkg SHALL hold FRAME_CYC, MIN_CYC, STEP_CYC, MAX_DEG (180), NEUTRAL_CYC (150_000) and the counter/width widths (21 bits).
REQ-025 One sub-module, servo_pwm_gen, SHALL contain the frame counter, the width register and the compare. top_servo SHALL hold input conversion, the control law and fault logic.
REQ-026 Real inputs SHALL be converted to integers only inside top_servo. All other logic SHALL be integer/fixed-width.

Verification
REQ-027 Reset 2 cycles, then release with grades=0, measure_grades=0, current=0 -> frame 1 high for 150_000 clocks; frame 2 onward high for 100_000 clocks of each 2_000_000.
REQ-028 grades=90.0, measure_grades=90.0 -> steady pulse of 149_950 clocks from the following frame.
REQ-029 grades=90.0, measure_grades=80.0 -> cmd 95, pulse 152_725. grades=90.0, measure_grades=100.0 -> cmd 85, pulse 147_175.
REQ-030 grades=200.0, measure_grades=180.0 -> clamp to 180, pulse 199_900. grades=-10.0 -> pulse 100_000 (with measure_grades=0).
REQ-031 Mid-pulse, drive measure_current=2.5 (also -2.5, separately) -> pwm_out 0 from the next edge and for all later frames. Then current=0 -> still 0. Then reset -> resumes at 150_000. current=2.0 -> no trip.
REQ-032 Change grades mid-frame -> current frame width unchanged; the new width appears only in the frame after the next boundary sample.
